// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, issues the start bit, shifts
// out data/parity/stop on device falling edges and checks the device acknowledge.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout
);

  localparam int MAXC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_ACK, S_WAIT_IDLE
  } state_t;

  state_t          r_state;
  logic [2:0]      r_clk_sync;
  logic [2:0]      r_data_sync;
  logic [9:0]      r_frame;
  logic [3:0]      r_idx;
  logic [CW-1:0]   r_cnt;
  logic            r_clk_oe;
  logic            r_data_oe;
  logic            r_done;
  logic            r_ack_err;
  logic            r_timeout;

  logic            w_fall;
  logic            w_data;
  logic            w_bus_idle;
  logic            w_progress;

  assign w_fall     = (r_clk_sync[2:1] == 2'b10);
  assign w_data     = r_data_sync[1];
  assign w_bus_idle = r_clk_sync[1] & r_data_sync[1];

  // Any event that resets the watchdog in the device-paced states.
  always_comb begin
    w_progress = 1'b0;
    case (r_state)
      S_SEND, S_ACK: w_progress = w_fall;
      S_WAIT_IDLE:   w_progress = w_bus_idle;
      default:       w_progress = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_clk_sync  <= 3'b111;
      r_data_sync <= 3'b111;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_clk_oe    <= 1'b0;
      r_data_oe   <= 1'b0;
      r_done      <= 1'b0;
      r_ack_err   <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_clk_sync  <= {r_clk_sync[1:0], ps2_clk_in};
      r_data_sync <= {r_data_sync[1:0], ps2_data_in};
      r_done      <= 1'b0;
      r_ack_err   <= 1'b0;
      r_timeout   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_clk_oe  <= 1'b0;
          r_data_oe <= 1'b0;
          if (tx_valid) begin
            r_frame  <= {1'b1, ~^tx_data, tx_data};
            r_idx    <= '0;
            r_cnt    <= '0;
            r_clk_oe <= 1'b1;
            r_state  <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (r_cnt == INH_LAST) begin
            r_data_oe <= 1'b1;
            r_state   <= S_REQ;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_REQ: begin
          // Releasing the clock with data held low is the request-to-send.
          r_clk_oe <= 1'b0;
          r_cnt    <= '0;
          r_state  <= S_SEND;
        end
        default: begin
          if (!w_progress) begin
            if (r_cnt == TO_LAST) begin
              r_timeout <= 1'b1;
              r_clk_oe  <= 1'b0;
              r_data_oe <= 1'b0;
              r_state   <= S_IDLE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else begin
            r_cnt <= '0;
            case (r_state)
              S_SEND: begin
                r_data_oe <= ~r_frame[r_idx];
                r_idx     <= r_idx + 1'b1;
                if (r_idx == 4'd9) r_state <= S_ACK;
              end
              S_ACK: begin
                r_data_oe <= 1'b0;
                if (!w_data) begin
                  r_state <= S_WAIT_IDLE;
                end else begin
                  r_ack_err <= 1'b1;
                  r_state   <= S_IDLE;
                end
              end
              default: begin
                r_done  <= 1'b1;
                r_state <= S_IDLE;
              end
            endcase
          end
        end
      endcase
    end
  end

  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;
  assign done        = r_done;
  assign ack_err     = r_ack_err;
  assign timeout     = r_timeout;
  assign tx_ready    = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);

endmodule
